// File: rtl/fir_out_requant.sv
// fir_out_requant
//   Sink-side companion to fir_filter. Decimates the signed filter output
//   stream, rounds (half-up) and saturates each kept value to OUT_W bits, and
//   buffers the results in a small FIFO with a valid/ready handshake.
//   The upstream filter cannot be stalled, so a full FIFO drops words and
//   records the event instead of applying backpressure.
//
//   Pipeline: input/accumulator stage -> requant stage -> FIFO with a
//   registered head word. A kept sample sampled at edge N is visible on
//   out_data_o with out_valid_o=1 after edge N+2 when the FIFO was empty.
//
//   Optional feature macro: FIR_OUT_REQUANT_AVG_EN
//     defined   : every DECIM-sample frame is summed and the sum is
//                 requantized with shift SHIFT+log2(DECIM).
//     undefined : the phase-0 sample of each frame is kept.
//
// Ports
//   clk_i         rising-edge clock
//   reset_i       synchronous active-high reset
//   in_valid_i    y_in_i carries a new sample this cycle
//   y_in_i        signed IN_W-bit filter sample
//   out_valid_o   out_data_o holds a valid word (FIFO non-empty)
//   out_ready_i   downstream accepts the word when out_valid_o is high
//   out_data_o    signed OUT_W-bit requantized sample
//   ovf_sticky_o  set when a word is dropped on a full FIFO
//   drop_count_o  saturating count of dropped words
//   sat_flag_o    high while the requant stage holds a clipped result
module fir_out_requant #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int SHIFT      = 4,
  parameter int DECIM      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    in_valid_i,
  input  logic signed [IN_W-1:0]  y_in_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [OUT_W-1:0] out_data_o,
  output logic                    ovf_sticky_o,
  output logic [7:0]              drop_count_o,
  output logic                    sat_flag_o
);

  localparam int LOGD = (DECIM > 1) ? $clog2(DECIM) : 0;
  localparam int PH_W = (DECIM > 1) ? LOGD : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
`ifdef FIR_OUT_REQUANT_AVG_EN
  localparam int ACC_W = IN_W + LOGD;
  localparam int ESH   = SHIFT + LOGD;
`else
  localparam int ACC_W = IN_W;
  localparam int ESH   = SHIFT;
`endif

  localparam logic [PH_W-1:0]     PH_LAST  = PH_W'(DECIM - 1);
  localparam logic [PH_W-1:0]     PH_ZERO  = {PH_W{1'b0}};
  localparam logic signed [ACC_W:0] RND     = (ACC_W + 1)'(2 ** (ESH - 1));
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(-(2 ** (OUT_W - 1)));

  // Round half-up, arithmetic shift, clip. Returns {clipped, value}.
  function automatic logic [OUT_W:0] requant(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] t;
    logic [OUT_W:0]        r;
    ext = {v[ACC_W-1], v};
    t   = (ext + RND) >>> ESH;
    if (t > SAT_MAX) begin
      r = {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (t < SAT_MIN) begin
      r = {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      r = {1'b0, t[OUT_W-1:0]};
    end
    return r;
  endfunction

  logic [PH_W-1:0]         phase_q, phase_d;
  logic                    s0_vld_q, s0_vld_d;
  logic signed [ACC_W-1:0] s0_val_q, s0_val_d;   // kept sample, or frame accumulator
  logic                    st_vld_q, st_vld_d;
  logic [OUT_W-1:0]        st_data_q, st_data_d;
  logic                    st_sat_q, st_sat_d;
  logic [AW:0]             wr_q, wr_d, rd_q, rd_d;
  logic [OUT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [OUT_W-1:0]        head_q, head_d;
  logic                    out_valid_q, out_valid_d;
  logic                    ovf_q, ovf_d;
  logic [7:0]              drop_q, drop_d;
  logic [OUT_W:0]          rq_s;
  logic                    full_s, pop_s, push_s, drop_s;

  // Next-state logic for decimation, requant stage and FIFO bookkeeping.
  always_comb begin
    phase_d     = phase_q;
    s0_vld_d    = 1'b0;
    s0_val_d    = s0_val_q;
    st_vld_d    = 1'b0;
    st_data_d   = st_data_q;
    st_sat_d    = 1'b0;
    wr_d        = wr_q;
    rd_d        = rd_q;
    head_d      = head_q;
    out_valid_d = 1'b0;
    ovf_d       = ovf_q;
    drop_d      = drop_q;
    rq_s        = requant(s0_val_q);

    if (in_valid_i) begin
      if (phase_q == PH_LAST) begin
        phase_d = PH_ZERO;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end else begin
      phase_d = phase_q;
    end

`ifdef FIR_OUT_REQUANT_AVG_EN
    // Phase 0 restarts the sum; the frame is handed on once its last sample is in.
    if (in_valid_i) begin
      if (phase_q == PH_ZERO) begin
        s0_val_d = ACC_W'(y_in_i);
      end else begin
        s0_val_d = s0_val_q + ACC_W'(y_in_i);
      end
      s0_vld_d = (phase_q == PH_LAST);
    end else begin
      s0_val_d = s0_val_q;
      s0_vld_d = 1'b0;
    end
`else
    if (in_valid_i && (phase_q == PH_ZERO)) begin
      s0_vld_d = 1'b1;
      s0_val_d = y_in_i;
    end else begin
      s0_vld_d = 1'b0;
      s0_val_d = s0_val_q;
    end
`endif

    st_vld_d = s0_vld_q;
    if (s0_vld_q) begin
      st_data_d = rq_s[OUT_W-1:0];
      st_sat_d  = rq_s[OUT_W];
    end else begin
      st_data_d = st_data_q;
      st_sat_d  = 1'b0;
    end

    full_s = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_s  = out_valid_q && out_ready_i;
    push_s = st_vld_q && (!full_s || pop_s);
    drop_s = st_vld_q && full_s && !pop_s;

    if (push_s) begin
      wr_d = wr_q + (AW + 1)'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_q + (AW + 1)'(1);
    end else begin
      rd_d = rd_q;
    end

    // The head word is registered; when the incoming word lands at the new
    // read slot it bypasses the memory.
    if (push_s && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
      head_d = st_data_q;
    end else begin
      head_d = mem_q[rd_d[AW-1:0]];
    end
    out_valid_d = (wr_d != rd_d);

    ovf_d = ovf_q | drop_s;
    if (drop_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Pipeline, pointer and status registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q     <= PH_ZERO;
      s0_vld_q    <= 1'b0;
      s0_val_q    <= {ACC_W{1'b0}};
      st_vld_q    <= 1'b0;
      st_data_q   <= {OUT_W{1'b0}};
      st_sat_q    <= 1'b0;
      wr_q        <= {(AW + 1){1'b0}};
      rd_q        <= {(AW + 1){1'b0}};
      head_q      <= {OUT_W{1'b0}};
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      phase_q     <= phase_d;
      s0_vld_q    <= s0_vld_d;
      s0_val_q    <= s0_val_d;
      st_vld_q    <= st_vld_d;
      st_data_q   <= st_data_d;
      st_sat_q    <= st_sat_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {OUT_W{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_q[AW-1:0]] <= st_data_q;
    end else begin
      mem_q[wr_q[AW-1:0]] <= mem_q[wr_q[AW-1:0]];
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = head_q;
  assign ovf_sticky_o = ovf_q;
  assign drop_count_o = drop_q;
  assign sat_flag_o   = st_sat_q;

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: a default instance (DECIM=2) and a
// DECIM=1 instance, both on one clock. Outputs are sampled 1 ns after the
// rising edge; inputs are changed at the same point.
module tb_fir_out_requant;

  logic              clk;
  logic              reset;
  logic              in_valid, out_ready;
  logic signed [15:0] y_in;
  logic              out_valid, ovf_sticky, sat_flag;
  logic signed [7:0]  out_data;
  logic [7:0]        drop_count;

  logic              d1_in_valid, d1_out_ready;
  logic signed [15:0] d1_y_in;
  logic              d1_out_valid, d1_ovf_sticky, d1_sat_flag;
  logic signed [7:0]  d1_out_data;
  logic [7:0]        d1_drop_count;

  int n_checks = 0;
  int n_errors = 0;

  fir_out_requant u_dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .y_in_i(y_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .ovf_sticky_o(ovf_sticky), .drop_count_o(drop_count), .sat_flag_o(sat_flag)
  );

  fir_out_requant #(.DECIM(1)) u_dut_d1 (
    .clk_i(clk), .reset_i(reset), .in_valid_i(d1_in_valid), .y_in_i(d1_y_in),
    .out_valid_o(d1_out_valid), .out_ready_i(d1_out_ready), .out_data_o(d1_out_data),
    .ovf_sticky_o(d1_ovf_sticky), .drop_count_o(d1_drop_count), .sat_flag_o(d1_sat_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic signed [15:0] y);
    in_valid = v;
    y_in     = y;
    tick();
  endtask

  int d1_vec  [4] = '{32767, -32768, -8, -9};
  int d1_exp  [4] = '{127, -128, 0, -1};
  int d1_sat  [4] = '{1, 1, 0, 0};
  int exp_seq [4] = '{2, 3, 4, 5};
  int words;

  initial begin
    reset = 1'b1; in_valid = 1'b0; y_in = 16'sd0; out_ready = 1'b1;
    d1_in_valid = 1'b0; d1_y_in = 16'sd0; d1_out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;

    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_ovf", 32'(ovf_sticky), 0);
    check_eq("rst_drop", 32'(drop_count), 0);
    check_eq("rst_sat", 32'(sat_flag), 0);
    check_eq("rst_d1_valid", 32'(d1_out_valid), 0);

`ifdef FIR_OUT_REQUANT_AVG_EN
    // Frame 100+60=160, shift 5: (160+16)>>5 = 5, two clocks after the last sample.
    step(1'b1, 16'sd100);
    step(1'b1, 16'sd60);
    step(1'b0, 16'sd0);
    check_eq("avg_not_yet", 32'(out_valid), 0);
    step(1'b0, 16'sd0);
    check_eq("avg_valid", 32'(out_valid), 1);
    check_eq("avg_data", 32'(out_data), 5);
    check_eq("avg_sat", 32'(sat_flag), 0);
    step(1'b0, 16'sd0);
    check_eq("avg_popped", 32'(out_valid), 0);
`else
    // Basic: 24 kept -> (24+8)>>4 = 2, 40 discarded.
    step(1'b1, 16'sd24);                  // edge N
    step(1'b1, 16'sd40);                  // edge N+1
    check_eq("basic_lat_n1", 32'(out_valid), 0);
    check_eq("basic_sat", 32'(sat_flag), 0);
    step(1'b0, 16'sd0);                   // edge N+2
    check_eq("basic_valid", 32'(out_valid), 1);
    check_eq("basic_data", 32'(out_data), 2);
    step(1'b0, 16'sd0);
    check_eq("basic_popped", 32'(out_valid), 0);
    step(1'b0, 16'sd0);
    check_eq("basic_only_one", 32'(out_valid), 0);

    // DECIM=1: rounding and saturation, sample k appears after edge k+2.
    for (int i = 0; i < 6; i++) begin
      d1_in_valid = (i < 4);
      d1_y_in = (i < 4) ? d1_vec[i][15:0] : 16'sd0;
      tick();
      if (i >= 1 && i <= 4) begin
        check_eq($sformatf("d1_sat_%0d", i - 1), 32'(d1_sat_flag), d1_sat[i - 1]);
      end else begin
        check_eq($sformatf("d1_sat_idle_%0d", i), 32'(d1_sat_flag), 0);
      end
      if (i >= 2) begin
        check_eq($sformatf("d1_valid_%0d", i - 2), 32'(d1_out_valid), 1);
        check_eq($sformatf("d1_data_%0d", i - 2), 32'(d1_out_data), d1_exp[i - 2]);
      end else begin
        check_eq($sformatf("d1_early_%0d", i), 32'(d1_out_valid), 0);
      end
    end
    d1_in_valid = 1'b0;
    tick();
    check_eq("d1_drained", 32'(d1_out_valid), 0);

    // Overflow: 12 samples of 16 with out_ready=0, 6 kept, 4 fit.
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b1, 16'sd16);
    check_eq("ovf_drop_mid", 32'(drop_count), 1);
    step(1'b0, 16'sd0);
    step(1'b0, 16'sd0);
    check_eq("ovf_drop", 32'(drop_count), 2);
    check_eq("ovf_sticky", 32'(ovf_sticky), 1);
    check_eq("ovf_valid", 32'(out_valid), 1);
    check_eq("ovf_head", 32'(out_data), 1);
    step(1'b0, 16'sd0);
    check_eq("ovf_stall_data", 32'(out_data), 1);
    check_eq("ovf_stall_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    words = 0;
    for (int i = 0; i < 7; i++) begin
      if (out_valid) begin
        words++;
        check_eq($sformatf("ovf_word_%0d", i), 32'(out_data), 1);
      end
      tick();
    end
    check_eq("ovf_words", words, 4);
    check_eq("ovf_sticky_kept", 32'(ovf_sticky), 1);

    // Reset with 3 words buffered, a word in flight and phase at 1.
    out_ready = 1'b0;
    step(1'b1, 16'sd16); step(1'b1, 16'sd0);
    step(1'b1, 16'sd32); step(1'b1, 16'sd0);
    step(1'b1, 16'sd48); step(1'b1, 16'sd0);
    step(1'b1, 16'sd64);
    check_eq("rst2_pre_valid", 32'(out_valid), 1);
    check_eq("rst2_pre_drop", 32'(drop_count), 2);
    reset = 1'b1;
    step(1'b0, 16'sd0);
    reset = 1'b0;
    check_eq("rst2_valid", 32'(out_valid), 0);
    check_eq("rst2_drop", 32'(drop_count), 0);
    check_eq("rst2_ovf", 32'(ovf_sticky), 0);
    step(1'b0, 16'sd0);
    step(1'b0, 16'sd0);
    check_eq("rst2_no_inflight", 32'(out_valid), 0);
    out_ready = 1'b1;
    step(1'b1, 16'sd80);                  // phase 0 after reset: kept -> 5
    step(1'b1, 16'sd96);
    step(1'b0, 16'sd0);
    check_eq("rst2_first_valid", 32'(out_valid), 1);
    check_eq("rst2_first_data", 32'(out_data), 5);
    step(1'b0, 16'sd0);
    check_eq("rst2_one_word", 32'(out_valid), 0);

    // Full FIFO with simultaneous push and pop: order kept, no drop.
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 16'(16 * k));
      step(1'b1, 16'sd0);
    end
    step(1'b1, 16'sd80);                  // 4th word lands: full
    step(1'b1, 16'sd0);                   // word 5 sits in the requant stage
    check_eq("full_head", 32'(out_data), 1);
    check_eq("full_drop_pre", 32'(drop_count), 0);
    out_ready = 1'b1;
    step(1'b0, 16'sd0);                   // pop 1, push 5
    check_eq("full_drop", 32'(drop_count), 0);
    check_eq("full_ovf", 32'(ovf_sticky), 0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("full_valid_%0d", i), 32'(out_valid), 1);
      check_eq($sformatf("full_order_%0d", i), 32'(out_data), exp_seq[i]);
      tick();
    end
    check_eq("full_empty", 32'(out_valid), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
- Sink-side companion to fir_filter: consumes the signed 16-bit filter output stream and produces a narrowed 8-bit sample stream.
- Decimates by DECIM, then rounds and saturates to OUT_W bits.
- Buffers results in a small FIFO with a valid/ready handshake toward downstream.
- fir_filter has no backpressure, so overflow is detected and counted, never stalled.

Parameters:
- IN_W, 16, input sample width (signed, two's complement).
- OUT_W, 8, output sample width (signed).
- SHIFT, 4, arithmetic right shift applied before saturation; must be 1..IN_W-1.
- DECIM, 2, decimation ratio; power of two, 1..16.
- FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, y_in carries a new filter sample this cycle.
- y_in, input, IN_W, signed filter output sample.
- out_valid, output, 1, out_data holds a valid word.
- out_ready, input, 1, downstream accepts the word when out_valid is also high.
- out_data, output, OUT_W, signed requantized sample.
- ovf_sticky, output, 1, set when a kept sample is dropped because the FIFO is full; cleared only by reset.
- drop_count, output, 8, number of dropped samples; saturates at 255.
- sat_flag, output, 1, one-cycle pulse when the sample entering the FIFO path was clipped.

Behaviour:
- Reset (synchronous, reset high at a rising edge):
  - out_valid=0, out_data=0, ovf_sticky=0, drop_count=0, sat_flag=0.
  - Decimation phase=0, FIFO empty, stage register invalid.
  - Reset has priority over every other event. Reset mid-stream discards all buffered and in-flight samples; the next accepted sample restarts at phase 0.
- Decimation:
  - Phase counter advances on each cycle with in_valid=1 and wraps at DECIM-1.
  - The sample accepted at phase 0 is kept; samples at all other phases are discarded.
  - DECIM=1 keeps every sample.
- Requantization, stage 1 (registered):
  - t = (sign-extended y_in to IN_W+1 bits + 2^(SHIFT-1)) >>> SHIFT. This is round-half-up.
  - If t > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1. If t < -2^(OUT_W-1), the result is -2^(OUT_W-1). Otherwise the result is t truncated to OUT_W bits.
  - sat_flag pulses in the cycle the stage register holds a clipped result.
- FIFO, stage 2:
  - A valid stage-register word is written at the next edge.
  - First-word latency: a kept sample presented at edge N appears on out_data with out_valid=1 after edge N+2, provided the FIFO was empty.
- Handshake:
  - Pop occurs when out_valid && out_ready.
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0.
  - out_valid=1 exactly when the FIFO is non-empty.
- Full FIFO:
  - With a push pending and no pop, the word is dropped. ovf_sticky is set and drop_count increments (saturating).
  - Simultaneous push and pop while full: both occur, with no drop.
  - Simultaneous push and pop while empty: no pop, since out_valid=0; the push lands.
- Wrap-around: read and write pointers wrap at FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.
- Outputs are registered; there is no combinational path from y_in or out_ready to out_data.

Optional Feature:
- Macro: FIR_OUT_REQUANT_AVG_EN.
- Defined:
  - Instead of picking the phase-0 sample, sum all DECIM samples of a frame in an IN_W+log2(DECIM) accumulator.
  - The kept value is the sum, requantized with effective shift SHIFT+log2(DECIM) using the same rounding and saturation.
  - The frame completes at phase DECIM-1, and the result enters stage 1 on the following edge, so latency from the last frame sample is 2 clocks.
  - Reset clears the accumulator.
- Undefined: pick-phase-0 behaviour as above; no accumulator is instantiated.

Test Plan:
- Defaults; in_valid=1 with y_in=24,40 and out_ready=1 -> one word out_data=2 (24 kept, 40 discarded), valid after edge N+2, sat_flag=0.
- DECIM=1; y_in=32767, then -32768, then -8, then -9 -> out_data=127, -128, 0, -1. sat_flag pulses for the first two only.
- out_ready=0; feed 12 samples of y_in=16 (6 kept) -> the FIFO holds 4 words of 1; drop_count=2, ovf_sticky=1. Then out_ready=1 drains exactly 4 words.
- FIFO full, out_ready=1 while a kept sample arrives -> pop and push occur in the same cycle; drop_count is unchanged and word order is preserved.
- Assert reset for one cycle with 3 words buffered -> next cycle out_valid=0, drop_count=0. The next kept sample is the first one accepted after reset.
- With FIR_OUT_REQUANT_AVG_EN and DECIM=2: y_in=100,60 -> sum 160, shift 5 -> out_data=5.
